// File: rtl/axi_vdma_sched_pkg.sv
// Shared types and constants for the AXI write burst scheduler.
package axi_vdma_sched_pkg;

    localparam int BYTES_PER_BEAT = 32;
    localparam int BEAT_SHIFT     = 5;
    localparam int BOUNDARY_4K    = 4096;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CALC      = 3'd1,
        WAIT_DATA = 3'd2,
        REQ       = 3'd3,
        WAIT_DONE = 3'd4,
        FINISH    = 3'd5
    } state_t;

endpackage

// File: rtl/axi_write_burst_scheduler_if.sv
// Burst request channel between the scheduler and the write state core.
//
// Handshake: the scheduler raises write_req with req_len/req_addr stable and
// holds all three until the core answers with a one-cycle req_resp (address
// phase taken). The core later pulses req_done once the write response is
// back; req_len/req_addr stay stable until that pulse has been consumed.
interface axi_write_burst_scheduler_if #(
    parameter int LSIZE = 10,
    parameter int ASIZE = 32
);
    logic             write_req;
    logic [LSIZE-1:0] req_len;
    logic [ASIZE-1:0] req_addr;
    logic             req_resp;
    logic             req_done;

    modport master (
        output write_req,
        output req_len,
        output req_addr,
        input  req_resp,
        input  req_done
    );

    modport slave (
        input  write_req,
        input  req_len,
        input  req_addr,
        output req_resp,
        output req_done
    );
endinterface

// File: rtl/axi_burst_len_calc.sv
// Picks the next burst length: the smallest of the beats left, the burst cap
// and the beats that fit before the next 4 KB page boundary.
module axi_burst_len_calc
    import axi_vdma_sched_pkg::*;
#(
    parameter int LSIZE     = 10,
    parameter int CSIZE     = 24,
    parameter int MAX_BURST = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             calc_en_i,
    input  logic [CSIZE-1:0] remain_i,
    input  logic [11:0]      page_off_i,
    output logic [LSIZE-1:0] len_o
);

    logic [12:0]      to_4k_bytes;
    logic [CSIZE-1:0] beats_4k;
    logic [CSIZE-1:0] cap;
    logic [CSIZE-1:0] pick;
    logic [LSIZE-1:0] len_q;

    // Three-way minimum; page_off is beat aligned so beats_4k is 1..128.
    always_comb begin
        to_4k_bytes = 13'(BOUNDARY_4K) - {1'b0, page_off_i};
        beats_4k    = CSIZE'(to_4k_bytes >> BEAT_SHIFT);
        cap         = CSIZE'(MAX_BURST);
        pick        = remain_i;
        if (cap < pick) begin
            pick = cap;
        end
        if (beats_4k < pick) begin
            pick = beats_4k;
        end
    end

    // Length is captured once per CALC and held for the whole burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
        end else if (calc_en_i) begin
            len_q <= pick[LSIZE-1:0];
        end
    end

    assign len_o = len_q;

endmodule

// File: rtl/axi_write_burst_scheduler.sv
// Splits a write transfer into AXI bursts that respect the burst cap, FIFO
// fill level and 4 KB boundaries, and sequences them through the write core.
module axi_write_burst_scheduler
    import axi_vdma_sched_pkg::*;
#(
    parameter int LSIZE     = 10,
    parameter int ASIZE     = 32,
    parameter int CSIZE     = 24,
    parameter int MAX_BURST = 128
) (
    input  logic                        axi_aclk,
    input  logic                        axi_reset,
    input  logic                        start,
    input  logic [CSIZE-1:0]            total_beats,
    input  logic [ASIZE-1:0]            base_addr,
    input  logic                        abort,
    input  logic [LSIZE:0]              fifo_count,
    output logic                        busy,
    output logic                        finish,
    output logic                        aborted,
    output logic [CSIZE-1:0]            burst_cnt,
    output state_t                      dbg_state_o,
    axi_write_burst_scheduler_if.master req_if
);

    state_t           state_q, state_d;
    logic [ASIZE-1:0] addr_q;
    logic [CSIZE-1:0] remain_q;
    logic [CSIZE-1:0] burst_cnt_q;
    logic             busy_q, finish_q, aborted_q, write_req_q;
    logic             abort_pend_q, done_pend_q, fifo_ok_q;
    logic [LSIZE-1:0] len;
    logic             accept_start, calc_en, burst_done, end_abort, done_seen;

    axi_burst_len_calc #(
        .LSIZE     (LSIZE),
        .CSIZE     (CSIZE),
        .MAX_BURST (MAX_BURST)
    ) u_len_calc (
        .clk        (axi_aclk),
        .rst        (axi_reset),
        .calc_en_i  (calc_en),
        .remain_i   (remain_q),
        .page_off_i (addr_q[11:0]),
        .len_o      (len)
    );

    assign done_seen = req_if.req_done | done_pend_q;

    // Next-state and control strobes for the burst sequencer.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        calc_en      = 1'b0;
        burst_done   = 1'b0;
        end_abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = (total_beats != '0) ? CALC : FINISH;
                end
            end
            CALC: begin
                calc_en = 1'b1;
                if (abort) begin
                    state_d   = FINISH;
                    end_abort = 1'b1;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (abort) begin
                    state_d   = FINISH;
                    end_abort = 1'b1;
                end else if (fifo_ok_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_if.req_resp) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_seen) begin
                    burst_done = 1'b1;
                    if (abort_pend_q || abort) begin
                        state_d   = FINISH;
                        end_abort = 1'b1;
                    end else if (remain_q == CSIZE'(len)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus the status outputs that follow it.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            write_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            finish_q    <= (state_q == FINISH);
            write_req_q <= (state_d == REQ);
        end
    end

    // FIFO level check is registered so fifo_count stays off the state
    // decision path; it is only meaningful after a full WAIT_DATA cycle.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            fifo_ok_q <= 1'b0;
        end else begin
            fifo_ok_q <= (state_q == WAIT_DATA) && (fifo_count >= {1'b0, len});
        end
    end

    // Transfer bookkeeping: address, beats left and completed bursts.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            addr_q      <= '0;
            remain_q    <= '0;
            burst_cnt_q <= '0;
        end else if (accept_start) begin
            addr_q      <= base_addr & ~ASIZE'(BYTES_PER_BEAT - 1);
            remain_q    <= total_beats;
            burst_cnt_q <= '0;
        end else if (burst_done) begin
            addr_q      <= addr_q + (ASIZE'(len) << BEAT_SHIFT);
            remain_q    <= remain_q - CSIZE'(len);
            burst_cnt_q <= burst_cnt_q + CSIZE'(1);
        end
    end

    // Abort latch, early req_done capture and the sticky aborted flag.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            abort_pend_q <= 1'b0;
            done_pend_q  <= 1'b0;
            aborted_q    <= 1'b0;
        end else if (accept_start) begin
            abort_pend_q <= 1'b0;
            done_pend_q  <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            if (abort && (state_q == REQ || state_q == WAIT_DONE)) begin
                abort_pend_q <= 1'b1;
            end
            if (state_q == REQ && req_if.req_resp && req_if.req_done) begin
                done_pend_q <= 1'b1;
            end else if (burst_done) begin
                done_pend_q <= 1'b0;
            end
            if (end_abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    assign busy             = busy_q;
    assign finish           = finish_q;
    assign aborted          = aborted_q;
    assign burst_cnt        = burst_cnt_q;
    assign dbg_state_o      = state_q;
    assign req_if.write_req = write_req_q;
    assign req_if.req_len   = len;
    assign req_if.req_addr  = addr_q;

endmodule

// File: tb/tb_axi_write_burst_scheduler.sv
// Directed bench for axi_write_burst_scheduler with a burst-plan model.
module tb_axi_write_burst_scheduler;
    import axi_vdma_sched_pkg::*;

    localparam int LSIZE     = 10;
    localparam int ASIZE     = 32;
    localparam int CSIZE     = 24;
    localparam int MAX_BURST = 128;

    logic             axi_aclk = 1'b0;
    logic             axi_reset;
    logic             start;
    logic [CSIZE-1:0] total_beats;
    logic [ASIZE-1:0] base_addr;
    logic             abort;
    logic [LSIZE:0]   fifo_count;
    logic             busy, finish, aborted;
    logic [CSIZE-1:0] burst_cnt;
    state_t           dbg_state;

    axi_write_burst_scheduler_if #(.LSIZE(LSIZE), .ASIZE(ASIZE)) rif ();

    axi_write_burst_scheduler #(
        .LSIZE     (LSIZE),
        .ASIZE     (ASIZE),
        .CSIZE     (CSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_reset   (axi_reset),
        .start       (start),
        .total_beats (total_beats),
        .base_addr   (base_addr),
        .abort       (abort),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .finish      (finish),
        .aborted     (aborted),
        .burst_cnt   (burst_cnt),
        .dbg_state_o (dbg_state),
        .req_if      (rif)
    );

    // ---------------- clock ----------------
    always #5 axi_aclk = ~axi_aclk;

    // ---------------- scoreboard state ----------------
    logic [41:0] exp_q[$];     // {len[9:0], addr[31:0]} per planned burst
    int          exp_cnt;
    logic        exp_aborted;
    int          n_checks = 0;
    int          n_pass   = 0;

    // write-core responder knobs
    bit resp_enable     = 1'b1;
    bit same_cycle_done = 1'b0;
    int resp_delay      = 1;
    int done_delay      = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    endtask

    // Burst plan from the transfer rules: each burst takes as many beats as
    // possible without exceeding the cap, the beats left or the 4 KB page.
    task automatic model_bursts(input int total, input logic [31:0] base, input int max_n);
        int     rem;
        longint a;
        int     room;
        int     len;
        exp_q.delete();
        exp_cnt = 0;
        rem = total;
        a   = longint'(base & 32'hFFFF_FFE0);
        while (rem > 0 && exp_cnt < max_n) begin
            room = (4096 - int'(a % 4096)) / 32;
            len  = rem;
            if (len > MAX_BURST) len = MAX_BURST;
            if (len > room) len = room;
            exp_q.push_back({10'(len), 32'(a)});
            a   = a + longint'(len * 32);
            rem = rem - len;
            exp_cnt++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input int total, input logic [31:0] base);
        start       = 1'b1;
        total_beats = CSIZE'(total);
        base_addr   = base;
        @(negedge axi_aclk);
        start       = 1'b0;
    endtask

    task automatic wait_finish(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge axi_aclk);
            if (finish) seen = 1'b1;
        end
        check({name, "_finish_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_wr(input logic level, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge axi_aclk);
            if (rif.write_req === level) seen = 1'b1;
        end
        check({name, "_write_req_level"}, 64'(seen), 64'd1);
    endtask

    // Write core: takes the address phase, later reports the response.
    initial begin : responder
        rif.req_resp = 1'b0;
        rif.req_done = 1'b0;
        forever begin
            @(negedge axi_aclk);
            if (rif.write_req === 1'b1 && resp_enable && !axi_reset) begin
                repeat (resp_delay) @(negedge axi_aclk);
                rif.req_resp = 1'b1;
                if (same_cycle_done) rif.req_done = 1'b1;
                @(negedge axi_aclk);
                rif.req_resp = 1'b0;
                rif.req_done = 1'b0;
                if (!same_cycle_done) begin
                    repeat (done_delay) @(negedge axi_aclk);
                    rif.req_done = 1'b1;
                    @(negedge axi_aclk);
                    rif.req_done = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the burst plan and transfer outcome.
    initial begin : compare
        logic        prev_wr;
        logic        prev_fin;
        logic [41:0] cur;
        bit          in_burst;
        prev_wr  = 1'b0;
        prev_fin = 1'b0;
        in_burst = 1'b0;
        cur      = '0;
        forever begin
            @(negedge axi_aclk);
            if (axi_reset !== 1'b0) begin
                prev_wr  = 1'b0;
                prev_fin = 1'b0;
                in_burst = 1'b0;
            end else begin
                if (rif.write_req === 1'b1 && !prev_wr) begin
                    check("req_planned", 64'(exp_q.size() != 0), 64'd1);
                    check("no_4k_cross",
                          64'(int'(rif.req_addr[11:0]) + int'(rif.req_len) * 32 <= 4096), 64'd1);
                    if (exp_q.size() != 0) begin
                        cur      = exp_q.pop_front();
                        in_burst = 1'b1;
                    end else begin
                        in_burst = 1'b0;
                    end
                end
                if (rif.write_req === 1'b1 && in_burst) begin
                    check("req_len", 64'(rif.req_len), 64'(cur[41:32]));
                    check("req_addr", 64'(rif.req_addr), 64'(cur[31:0]));
                end
                if (finish === 1'b1) begin
                    check("fin_burst_cnt", 64'(burst_cnt), 64'(exp_cnt));
                    check("fin_aborted", 64'(aborted), 64'(exp_aborted));
                    check("fin_plan_drained", 64'(exp_q.size()), 64'd0);
                    check("fin_busy_low", 64'(busy), 64'd0);
                    check("fin_single_cycle", 64'(prev_fin), 64'd0);
                end
                prev_wr  = rif.write_req;
                prev_fin = finish;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin : main
        axi_reset   = 1'b1;
        start       = 1'b0;
        total_beats = '0;
        base_addr   = '0;
        abort       = 1'b0;
        fifo_count  = '0;
        exp_cnt     = 0;
        exp_aborted = 1'b0;

        // reset state
        repeat (3) @(negedge axi_aclk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_write_req", 64'(rif.write_req), 64'd0);
        check("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        check("rst_req_len", 64'(rif.req_len), 64'd0);
        check("rst_req_addr", 64'(rif.req_addr), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        axi_reset = 1'b0;
        @(negedge axi_aclk);

        // 300 beats from 0x1000 with plenty of data
        fifo_count = 11'd200;
        model_bursts(300, 32'h1000, 100);
        exp_aborted = 1'b0;
        check("model_a_cnt", 64'(exp_cnt), 64'd3);
        check("model_a_b0", 64'(exp_q[0]), {22'd0, 10'd128, 32'h0000_1000});
        check("model_a_b1", 64'(exp_q[1]), {22'd0, 10'd128, 32'h0000_2000});
        check("model_a_b2", 64'(exp_q[2]), {22'd0, 10'd44, 32'h0000_3000});
        do_start(300, 32'h1000);
        wait_finish(2000, "a");
        check("a_burst_cnt", 64'(burst_cnt), 64'd3);
        @(negedge axi_aclk);
        check("a_cnt_hold", 64'(burst_cnt), 64'd3);
        check("a_aborted", 64'(aborted), 64'd0);
        check("a_finish_dropped", 64'(finish), 64'd0);

        // 4 KB split with req_done arriving together with req_resp
        same_cycle_done = 1'b1;
        model_bursts(10, 32'h0FC0, 100);
        check("model_b_b0", 64'(exp_q[0]), {22'd0, 10'd2, 32'h0000_0FC0});
        check("model_b_b1", 64'(exp_q[1]), {22'd0, 10'd8, 32'h0000_1000});
        do_start(10, 32'h0FC0);
        wait_finish(1000, "b");
        check("b_burst_cnt", 64'(burst_cnt), 64'd2);
        same_cycle_done = 1'b0;
        @(negedge axi_aclk);

        // FIFO starved, ignored restart, then data arrives
        fifo_count = 11'd10;
        model_bursts(128, 32'h0, 100);
        check("model_c_b0", 64'(exp_q[0]), {22'd0, 10'd128, 32'h0000_0000});
        do_start(128, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge axi_aclk);
            check("c_starved_low", 64'(rif.write_req), 64'd0);
        end
        do_start(5, 32'h40);
        fifo_count = 11'd128;
        @(negedge axi_aclk);
        check("c_fifo_plus1", 64'(rif.write_req), 64'd0);
        @(negedge axi_aclk);
        check("c_fifo_plus2", 64'(rif.write_req), 64'd1);
        wait_finish(1000, "c");
        check("c_burst_cnt", 64'(burst_cnt), 64'd1);
        @(negedge axi_aclk);

        // abort during WAIT_DONE of the first of three bursts
        fifo_count = 11'd200;
        done_delay = 6;
        model_bursts(300, 32'h0, 1);
        exp_aborted = 1'b1;
        do_start(300, 32'h0);
        wait_wr(1'b1, 100, "d_rise");
        wait_wr(1'b0, 100, "d_fall");
        abort = 1'b1;
        @(negedge axi_aclk);
        abort = 1'b0;
        wait_finish(1000, "d");
        check("d_burst_cnt", 64'(burst_cnt), 64'd1);
        @(negedge axi_aclk);
        check("d_aborted_hold", 64'(aborted), 64'd1);
        done_delay = 2;

        // abort while waiting for FIFO data
        fifo_count = 11'd10;
        model_bursts(128, 32'h0, 0);
        exp_aborted = 1'b1;
        do_start(128, 32'h0);
        repeat (4) @(negedge axi_aclk);
        abort = 1'b1;
        @(negedge axi_aclk);
        abort = 1'b0;
        wait_finish(100, "e");
        check("e_burst_cnt", 64'(burst_cnt), 64'd0);
        check("e_aborted", 64'(aborted), 64'd1);
        fifo_count = 11'd200;
        @(negedge axi_aclk);

        // zero-length transfer: finish two cycles after start
        model_bursts(0, 32'h80, 100);
        exp_aborted = 1'b0;
        do_start(0, 32'h80);
        check("f_busy_plus1", 64'(busy), 64'd1);
        check("f_finish_plus1", 64'(finish), 64'd0);
        @(negedge axi_aclk);
        check("f_finish_plus2", 64'(finish), 64'd1);
        check("f_aborted", 64'(aborted), 64'd0);
        @(negedge axi_aclk);

        // reset pulsed while a request is outstanding
        resp_enable = 1'b0;
        model_bursts(50, 32'h200, 100);
        do_start(50, 32'h200);
        wait_wr(1'b1, 100, "g_rise");
        axi_reset = 1'b1;
        @(negedge axi_aclk);
        check("g_write_req", 64'(rif.write_req), 64'd0);
        check("g_state", 64'(dbg_state), 64'(IDLE));
        check("g_busy", 64'(busy), 64'd0);
        axi_reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge axi_aclk);
            check("g_no_finish", 64'(finish), 64'd0);
        end
        resp_enable = 1'b1;

        // unaligned base one beat below a page boundary
        model_bursts(33, 32'h0FE5, 100);
        exp_aborted = 1'b0;
        check("model_h_b0", 64'(exp_q[0]), {22'd0, 10'd1, 32'h0000_0FE0});
        check("model_h_b1", 64'(exp_q[1]), {22'd0, 10'd32, 32'h0000_1000});
        do_start(33, 32'h0FE5);
        wait_finish(1000, "h");
        check("h_burst_cnt", 64'(burst_cnt), 64'd2);
        repeat (3) @(negedge axi_aclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_write_burst_scheduler.md
AXI_WRITE_BURST_SCHEDULER -- requirements
Module: axi_write_burst_scheduler

Interface
REQ-001 SHALL have parameter LSIZE, default 10: width of the burst-length field (req_len).
REQ-002 SHALL have parameter ASIZE, default 32: address width.
REQ-003 SHALL have parameter CSIZE, default 24: width of the total-beat count.
REQ-004 SHALL have parameter MAX_BURST, default 128: maximum beats per burst, legal range 1..2**LSIZE-1.
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports axi_aclk and axi_reset.
REQ-006 axi_aclk  in  1  clock.
REQ-007 axi_reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  single-cycle pulse that begins a transfer.
REQ-009 total_beats  in  CSIZE  beats to write; sampled on start.
REQ-010 base_addr  in  ASIZE  byte start address; sampled on start; bits [4:0] forced to 0.
REQ-011 abort  in  1  level request to stop the transfer early.
REQ-012 fifo_count  in  LSIZE+1  beats currently available in the source FIFO.
REQ-013 busy  out  1  high from the cycle after start until the cycle finish pulses.
REQ-014 finish  out  1  single-cycle completion pulse.
REQ-015 aborted  out  1  qualifies finish; high when the transfer ended by abort.
REQ-016 burst_cnt  out  CSIZE  bursts completed in the current transfer.
REQ-017 write_req  out  1  burst request to the write state core.
REQ-018 req_len  out  LSIZE  burst length in beats (1..MAX_BURST).
REQ-019 req_addr  out  ASIZE  burst byte address.
REQ-020 req_resp  in  1  write core accepted the address phase.
REQ-021 req_done  in  1  write core received the write response.

Function
REQ-022 States SHALL be IDLE, CALC, WAIT_DATA, REQ, WAIT_DONE, FINISH.
REQ-023 IDLE: start with total_beats!=0 SHALL latch the inputs and move to CALC; start with total_beats==0 SHALL move to FINISH, aborted=0; start SHALL be ignored outside IDLE.
REQ-024 CALC, one cycle: len SHALL be min(remaining, MAX_BURST, beats_to_4k), where beats_to_4k = (4096 - addr[11:0]) >> 5; then move to WAIT_DATA.
REQ-025 WAIT_DATA: fifo_count >= len SHALL move to REQ.
REQ-026 REQ: write_req SHALL be high in every REQ cycle; req_resp SHALL move to WAIT_DONE, so write_req is low the cycle after req_resp.
REQ-027 WAIT_DONE: req_done SHALL trigger, on the same edge: addr += len*32, remaining -= len, burst_cnt += 1; then move to FINISH if remaining reaches 0 or abort is latched, else to CALC.
REQ-028 FINISH: finish SHALL be high for exactly one cycle; then move to IDLE.
REQ-029 req_len and req_addr SHALL be registered and stable from REQ entry until WAIT_DONE exits.
REQ-030 abort in CALC or WAIT_DATA SHALL move to FINISH with aborted=1 and issue no further request.
REQ-031 abort in REQ or WAIT_DONE SHALL be latched; the outstanding burst completes, then FINISH with aborted=1.
REQ-032 req_done arriving in the same cycle as req_resp (while in REQ) SHALL be held pending and consumed in WAIT_DONE.
REQ-033 Bursts SHALL never cross a 4 KB address boundary.
REQ-034 remaining SHALL never underflow; subtraction uses CSIZE bits.
REQ-035 burst_cnt SHALL clear on an accepted start and hold after finish.
REQ-036 aborted SHALL hold its value until the next accepted start.

Reset
REQ-037 axi_reset SHALL force state IDLE and busy, finish, aborted, write_req = 0, burst_cnt, req_len = 0, and req_addr = 0.
REQ-038 Reset asserted mid-transfer SHALL drop write_req on the next edge and emit no finish.

Structure
REQ-039 A shared package axi_vdma_sched_pkg SHALL hold the state enum, BYTES_PER_BEAT=32, BEAT_SHIFT=5 and BOUNDARY_4K=4096.
REQ-040 The burst-length min/4K computation SHALL be one sub-module, axi_burst_len_calc, registered once per CALC.

Verification
REQ-041 total_beats=300, base_addr=0x1000, fifo_count=200 constant -> bursts 128@0x1000, 128@0x2000, 44@0x3000; burst_cnt=3; finish with aborted=0.
REQ-042 base_addr=0x0FC0, total_beats=10 -> bursts 2@0x0FC0, 8@0x1000; no 4K crossing.
REQ-043 fifo_count=10, len=128 -> write_req stays low until fifo_count=128, rises 2 cycles later.
REQ-044 abort during WAIT_DONE of burst 1 of 3 -> req_done accepted, finish with aborted=1, burst_cnt=1, no second write_req.
REQ-045 start with total_beats=0 -> finish 2 cycles later, write_req never asserted.
REQ-046 axi_reset pulsed in REQ -> write_req low next cycle, state IDLE, no finish.
